// File: rtl/exc_pkg.sv
// -----------------------------------------------------------------------------
// exc_pkg
// Shared definitions for the exception pipeline tracker.
//   - excState_t : commit FSM states (IDLE tracking, PEND waiting for CP0,
//                  FLUSH one-cycle kill pulse)
//   - EXC_*      : exception code constants used by CP0 (0 = interrupt)
//   - codeIsKnown: helper that tells whether a code is one of the named causes
// No ports (package).
// -----------------------------------------------------------------------------
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } excState_t;

    localparam int EXC_INT  = 0;
    localparam int EXC_ADEL = 4;
    localparam int EXC_ADES = 5;
    localparam int EXC_RI   = 10;
    localparam int EXC_OV   = 12;

    // True when the code matches one of the causes named above.
    function automatic logic codeIsKnown(input int code);
        return (code == EXC_INT)  || (code == EXC_ADEL) || (code == EXC_ADES) ||
               (code == EXC_RI)   || (code == EXC_OV);
    endfunction

endpackage

// File: rtl/exc_stage_reg.sv
// -----------------------------------------------------------------------------
// exc_stage_reg
// One inter-stage exception register {valid, code, epc} with merge, hold,
// bubble and clear behaviour.
// Build option: EXC_TRACKER_EPC_EN -- when defined the epc field is stored,
// otherwise no epc flops exist and epc_o is tied to zero.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   inValid_i/inCode_i/inEpc_i : entry arriving from the previous register
//   req_i/reqCode_i/reqEpc_i   : exception raised by this stage
//   hold_i          : keep current contents
//   bubble_i        : previous register is held, load an empty entry
//   freeze_i        : commit pending, keep current contents
//   clear_i         : kill contents (flush)
//   valid_o/code_o/epc_o       : registered entry
// -----------------------------------------------------------------------------
module exc_stage_reg
    import exc_pkg::*;
#(
    parameter int CODE_W = 5,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inValid_i,
    input  logic [CODE_W-1:0] inCode_i,
    input  logic [ADDR_W-1:0] inEpc_i,
    input  logic              req_i,
    input  logic [CODE_W-1:0] reqCode_i,
    input  logic [ADDR_W-1:0] reqEpc_i,
    input  logic              hold_i,
    input  logic              bubble_i,
    input  logic              freeze_i,
    input  logic              clear_i,
    output logic              valid_o,
    output logic [CODE_W-1:0] code_o,
    output logic [ADDR_W-1:0] epc_o
);

    logic              valid_q, valid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              keep;
    logic              load;
    logic              takeIn;
    logic              takeReq;

    // An older exception travelling down the pipe always beats a new one
    // raised here, so the incoming entry is taken before the local request.
    assign keep    = freeze_i | hold_i;
    assign load    = !clear_i && !keep && !bubble_i;
    assign takeIn  = load && inValid_i;
    assign takeReq = load && !inValid_i && req_i;

    // Next-state selection: clear wins over everything, then keep, then the
    // merged entry (which is empty when a bubble is inserted).
    always_comb begin
        valid_d = 1'b0;
        code_d  = code_q;
        if (!clear_i && keep) begin
            valid_d = valid_q;
        end else begin
            valid_d = takeIn | takeReq;
        end
        if (takeIn) begin
            code_d = inCode_i;
        end else if (takeReq) begin
            code_d = reqCode_i;
        end
    end

    // Entry register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            code_q  <= '0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
        end
    end

    assign valid_o = valid_q;
    assign code_o  = code_q;

`ifdef EXC_TRACKER_EPC_EN
    logic [ADDR_W-1:0] epc_q, epc_d;

    // EPC follows whichever entry was captured into the code field.
    always_comb begin
        epc_d = epc_q;
        if (takeIn) begin
            epc_d = inEpc_i;
        end else if (takeReq) begin
            epc_d = reqEpc_i;
        end
    end

    // EPC register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc_q <= '0;
        end else begin
            epc_q <= epc_d;
        end
    end

    assign epc_o = epc_q;
`else
    logic unusedEpc;
    assign unusedEpc = ^{inEpc_i, reqEpc_i};
    assign epc_o     = '0;
`endif

endmodule

// File: rtl/exc_pipe_tracker.sv
// -----------------------------------------------------------------------------
// exc_pipe_tracker
// Tracks exceptions raised by an NSTAGE pipeline, keeps the earliest one per
// instruction as it travels down, and hands the final-stage result (or an
// external interrupt) to CP0 with a commit/ack handshake followed by a
// one-cycle flush pulse.
// Build option: EXC_TRACKER_EPC_EN -- when defined EPCs are tracked; when
// undefined stage_pc is ignored and commit_epc is tied to zero.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   exc_req       : per-stage exception raise (bit 0 = fetch)
//   exc_code      : per-stage exception code, slice i = stage i
//   stage_pc      : per-stage PC, slice i = stage i
//   hold          : hold[i] freezes the register between stage i and i+1
//   int_req       : level-sensitive external interrupt
//   commit_ack    : CP0 accepted the committed exception
//   commit_valid  : exception/interrupt pending to CP0
//   commit_code   : committed code (0 = interrupt)
//   commit_epc    : PC of the faulting instruction
//   flush         : one-cycle pulse killing all in-flight instructions
// -----------------------------------------------------------------------------
module exc_pipe_tracker
    import exc_pkg::*;
#(
    parameter int NSTAGE = 4,
    parameter int CODE_W = 5,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NSTAGE-1:0]        exc_req,
    input  logic [NSTAGE*CODE_W-1:0] exc_code,
    input  logic [NSTAGE*ADDR_W-1:0] stage_pc,
    input  logic [NSTAGE-2:0]        hold,
    input  logic                     int_req,
    input  logic                     commit_ack,
    output logic                     commit_valid,
    output logic [CODE_W-1:0]        commit_code,
    output logic [ADDR_W-1:0]        commit_epc,
    output logic                     flush
);

    localparam int NREG = NSTAGE - 1;
    localparam int LAST = NSTAGE - 1;

    excState_t         state_q, state_d;
    logic [NREG-1:0]   regValid;
    logic [CODE_W-1:0] regCode [NREG];
    logic [ADDR_W-1:0] regEpc  [NREG];
    logic              freezeRegs;
    logic              clearRegs;
    logic              finalValid;
    logic [CODE_W-1:0] finalCode;
    logic              commitReq;
    logic [CODE_W-1:0] newCode;
    logic              loadCommit;
    logic [CODE_W-1:0] commitCode_q, commitCode_d;

    // While CP0 has not answered the whole pipe is frozen; once it answers,
    // and for the flush cycle after, every in-flight entry is killed.
    assign freezeRegs = (state_q == PEND) && !commit_ack;
    assign clearRegs  = ((state_q == PEND) && commit_ack) || (state_q == FLUSH);

    // Chain of inter-stage registers. Register i is fed by register i-1 and
    // gets a bubble when register i-1 is held but it is not.
    for (genvar i = 0; i < NREG; i++) begin : g_stage
        logic              inValid;
        logic [CODE_W-1:0] inCode;
        logic [ADDR_W-1:0] inEpc;
        logic              bubble;

        if (i == 0) begin : g_head
            assign inValid = 1'b0;
            assign inCode  = '0;
            assign inEpc   = '0;
            assign bubble  = 1'b0;
        end else begin : g_body
            assign inValid = regValid[i-1];
            assign inCode  = regCode[i-1];
            assign inEpc   = regEpc[i-1];
            assign bubble  = hold[i-1];
        end

        exc_stage_reg #(
            .CODE_W (CODE_W),
            .ADDR_W (ADDR_W)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .inValid_i (inValid),
            .inCode_i  (inCode),
            .inEpc_i   (inEpc),
            .req_i     (exc_req[i]),
            .reqCode_i (exc_code[i*CODE_W +: CODE_W]),
            .reqEpc_i  (stage_pc[i*ADDR_W +: ADDR_W]),
            .hold_i    (hold[i]),
            .bubble_i  (bubble),
            .freeze_i  (freezeRegs),
            .clear_i   (clearRegs),
            .valid_o   (regValid[i]),
            .code_o    (regCode[i]),
            .epc_o     (regEpc[i])
        );
    end

    // Final stage merge: an entry from upstream beats a raise in the last
    // stage, and any exception beats the external interrupt.
    always_comb begin
        finalValid = regValid[LAST-1] | exc_req[LAST];
        finalCode  = regValid[LAST-1] ? regCode[LAST-1]
                                      : exc_code[LAST*CODE_W +: CODE_W];
        commitReq  = finalValid | int_req;
        newCode    = finalValid ? finalCode : CODE_W'(EXC_INT);
    end

    // Commit FSM next-state: IDLE captures a result, PEND waits for the ack,
    // FLUSH lasts one cycle and ignores all requests.
    always_comb begin
        state_d    = state_q;
        loadCommit = 1'b0;
        case (state_q)
            IDLE: begin
                if (commitReq) begin
                    state_d    = PEND;
                    loadCommit = 1'b1;
                end
            end
            PEND: begin
                if (commit_ack) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops any pending commit without a flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign commitCode_d = loadCommit ? newCode : commitCode_q;

    // Committed code is only loaded on the IDLE->PEND transition, so it stays
    // stable for as long as CP0 takes to answer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commitCode_q <= '0;
        end else begin
            commitCode_q <= commitCode_d;
        end
    end

    assign commit_valid = (state_q == PEND);
    assign flush        = (state_q == FLUSH);
    assign commit_code  = commitCode_q;

`ifdef EXC_TRACKER_EPC_EN
    logic [ADDR_W-1:0] newEpc;
    logic [ADDR_W-1:0] commitEpc_q, commitEpc_d;

    // Interrupts and last-stage raises both use the PC in the final stage.
    assign newEpc      = regValid[LAST-1] ? regEpc[LAST-1]
                                          : stage_pc[LAST*ADDR_W +: ADDR_W];
    assign commitEpc_d = loadCommit ? newEpc : commitEpc_q;

    // Committed EPC register, loaded alongside the code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commitEpc_q <= '0;
        end else begin
            commitEpc_q <= commitEpc_d;
        end
    end

    assign commit_epc = commitEpc_q;
`else
    logic unusedPc;
    assign unusedPc   = ^{stage_pc[LAST*ADDR_W +: ADDR_W], regEpc[LAST-1]};
    assign commit_epc = '0;
`endif

endmodule

// File: tb/tb_exc_pipe_tracker.sv
// -----------------------------------------------------------------------------
// tb_exc_pipe_tracker
// Directed, table-driven bench for exc_pipe_tracker (NSTAGE=4, CODE_W=5,
// ADDR_W=32). Each table row gives the inputs for one cycle and the outputs
// expected just after the following rising edge.
// Honours EXC_TRACKER_EPC_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_exc_pipe_tracker;
    import exc_pkg::*;

    localparam int NSTAGE = 4;
    localparam int CODE_W = 5;
    localparam int ADDR_W = 32;

    logic                     clk;
    logic                     reset;
    logic [NSTAGE-1:0]        exc_req;
    logic [NSTAGE*CODE_W-1:0] exc_code;
    logic [NSTAGE*ADDR_W-1:0] stage_pc;
    logic [NSTAGE-2:0]        hold;
    logic                     int_req;
    logic                     commit_ack;
    logic                     commit_valid;
    logic [CODE_W-1:0]        commit_code;
    logic [ADDR_W-1:0]        commit_epc;
    logic                     flush;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  req;
        logic [4:0]  code;
        logic [2:0]  hold;
        logic        intReq;
        logic        ack;
        logic        expValid;
        logic [4:0]  expCode;
        logic [31:0] expPc;
        logic        expFlush;
    } vec_t;

    vec_t vecs[$];

    exc_pipe_tracker #(
        .NSTAGE (NSTAGE),
        .CODE_W (CODE_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .exc_req      (exc_req),
        .exc_code     (exc_code),
        .stage_pc     (stage_pc),
        .hold         (hold),
        .int_req      (int_req),
        .commit_ack   (commit_ack),
        .commit_valid (commit_valid),
        .commit_code  (commit_code),
        .commit_epc   (commit_epc),
        .flush        (flush)
    );

    // 10 time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed PC per stage so the committed EPC identifies the capturing stage.
    function automatic logic [31:0] pcOf(input int stage);
        return 32'h0040_1000 + 32'(stage) * 32'h100;
    endfunction

    // Expected EPC for a given raw PC, depending on the build option.
    function automatic logic [31:0] epcModel(input logic [31:0] pc);
`ifdef EXC_TRACKER_EPC_EN
        return pc;
`else
        return (pc & 32'h0);
`endif
    endfunction

    function automatic vec_t mkVec(input string name, input logic [3:0] req,
                                   input logic [4:0] code, input logic [2:0] hd,
                                   input logic intReq, input logic ack,
                                   input logic expValid, input logic [4:0] expCode,
                                   input logic [31:0] expPc, input logic expFlush);
        vec_t v;
        v.name     = name;
        v.req      = req;
        v.code     = code;
        v.hold     = hd;
        v.intReq   = intReq;
        v.ack      = ack;
        v.expValid = expValid;
        v.expCode  = expCode;
        v.expPc    = expPc;
        v.expFlush = expFlush;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Non-requesting stages carry a junk code so a wrong slice shows up.
    task automatic applyStimulus(input vec_t v);
        exc_req = v.req;
        for (int i = 0; i < NSTAGE; i++) begin
            exc_code[i*CODE_W +: CODE_W] = v.req[i] ? v.code : 5'(31 - i);
        end
        hold       = v.hold;
        int_req    = v.intReq;
        commit_ack = v.ack;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic runRow(input vec_t v);
        applyStimulus(v);
        step();
        checkOutput({v.name, ".valid"}, 32'(commit_valid), 32'(v.expValid));
        checkOutput({v.name, ".flush"}, 32'(flush), 32'(v.expFlush));
        if (v.expValid) begin
            checkOutput({v.name, ".code"}, 32'(commit_code), 32'(v.expCode));
            checkOutput({v.name, ".epc"}, commit_epc, epcModel(v.expPc));
        end
    endtask

    // Safety net: the run is a fixed number of cycles, this only fires if
    // simulation somehow stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [4:0] cAdel;
        logic [4:0] cAdes;
        logic [4:0] cRi;
        logic [4:0] cOv;
        logic [4:0] cInt;
        vec_t       v;

        cAdel = 5'(EXC_ADEL);
        cAdes = 5'(EXC_ADES);
        cRi   = 5'(EXC_RI);
        cOv   = 5'(EXC_OV);
        cInt  = 5'(EXC_INT);

        reset      = 1'b0;
        exc_req    = '0;
        exc_code   = '0;
        hold       = '0;
        int_req    = 1'b0;
        commit_ack = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            stage_pc[i*ADDR_W +: ADDR_W] = pcOf(i);
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.valid", 32'(commit_valid), 32'd0);
        checkOutput("reset.code", 32'(commit_code), 32'd0);
        checkOutput("reset.epc", commit_epc, 32'd0);
        checkOutput("reset.flush", 32'(flush), 32'd0);
        reset = 1'b1;
        step();

        // Fetch-stage ADEL travels 4 cycles, then ack produces a flush pulse.
        vecs.push_back(mkVec("a.s0raise", 4'b0001, cAdel, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec("a.s1", 4'b0000, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec("a.s2", 4'b0000, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec("a.commit", 4'b0000, 0, 3'b000, 0, 0, 1, cAdel, pcOf(0), 0));
        vecs.push_back(mkVec("a.ack", 4'b0000, 0, 3'b000, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mkVec("a.idle", 4'b0000, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        // Same instruction raises ADEL in stage 0 then RI in stage 1.
        vecs.push_back(mkVec("b.s0", 4'b0001, cAdel, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec("b.s1dup", 4'b0010, cRi, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec("b.s2", 4'b0000, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec("b.commit", 4'b0000, 0, 3'b000, 0, 0, 1, cAdel, pcOf(0), 0));
        vecs.push_back(mkVec("b.ack", 4'b0000, 0, 3'b000, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mkVec("b.idle", 4'b0000, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        // Final-stage OV beats a simultaneous interrupt; interrupt follows.
        vecs.push_back(mkVec("c.finalOv", 4'b1000, cOv, 3'b000, 1, 0, 1, cOv, pcOf(3), 0));
        vecs.push_back(mkVec("c.pend", 4'b0000, 0, 3'b000, 1, 0, 1, cOv, pcOf(3), 0));
        vecs.push_back(mkVec("c.ack", 4'b0000, 0, 3'b000, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mkVec("c.flushIgnInt", 4'b0000, 0, 3'b000, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec("c.intCommit", 4'b0000, 0, 3'b000, 1, 0, 1, cInt, pcOf(3), 0));
        vecs.push_back(mkVec("c.ack2", 4'b0000, 0, 3'b000, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mkVec("c.idle", 4'b0000, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        // Ack withheld 5 cycles; ADES raised in stage 2 meanwhile is dropped.
        vecs.push_back(mkVec("d.s2", 4'b0100, cRi, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec("d.commit", 4'b0000, 0, 3'b000, 0, 0, 1, cRi, pcOf(2), 0));
        vecs.push_back(mkVec("d.stall0", 4'b0100, cAdes, 3'b000, 0, 0, 1, cRi, pcOf(2), 0));
        vecs.push_back(mkVec("d.stall1", 4'b0000, 0, 3'b000, 0, 0, 1, cRi, pcOf(2), 0));
        vecs.push_back(mkVec("d.stall2", 4'b0000, 0, 3'b000, 0, 0, 1, cRi, pcOf(2), 0));
        vecs.push_back(mkVec("d.stall3", 4'b0000, 0, 3'b000, 0, 0, 1, cRi, pcOf(2), 0));
        vecs.push_back(mkVec("d.stall4", 4'b0000, 0, 3'b000, 0, 0, 1, cRi, pcOf(2), 0));
        vecs.push_back(mkVec("d.ack", 4'b0000, 0, 3'b000, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mkVec("d.after0", 4'b0000, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec("d.after1", 4'b0000, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkVec("d.after2", 4'b0000, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        // Ack while nothing is pending does nothing.
        vecs.push_back(mkVec("e.ackIdle", 4'b0000, 0, 3'b000, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mkVec("e.idle", 4'b0000, 0, 3'b000, 0, 0, 0, 0, 0, 0));

        for (int k = 0; k < vecs.size(); k++) begin
            runRow(vecs[k]);
        end

        // Hold register 1 for three cycles while it carries a stage-1 RI:
        // commit moves from the 3rd to the 6th edge and appears only once.
        for (int c = 0; c < 6; c++) begin
            v = mkVec($sformatf("hold.c%0d", c),
                      (c == 0) ? 4'b0010 : 4'b0000, cRi,
                      (c >= 1 && c <= 3) ? 3'b010 : 3'b000,
                      0, 0, (c == 5), cRi, pcOf(1), 0);
            runRow(v);
        end
        runRow(mkVec("hold.ack", 4'b0000, 0, 3'b000, 0, 1, 0, 0, 0, 1));
        for (int c = 0; c < 4; c++) begin
            runRow(mkVec($sformatf("hold.nodup%0d", c), 4'b0000, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        end

        // Reset while PEND, with a second exception already in register 0.
        runRow(mkVec("rst.arm", 4'b1001, cAdel, 3'b000, 0, 0, 1, cAdel, pcOf(3), 0));
        applyStimulus(mkVec("rst.quiet", 4'b0000, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst.validNow", 32'(commit_valid), 32'd0);
        checkOutput("rst.flushNow", 32'(flush), 32'd0);
        for (int c = 0; c < 2; c++) begin
            step();
            checkOutput($sformatf("rst.held%0d.flush", c), 32'(flush), 32'd0);
            checkOutput($sformatf("rst.held%0d.valid", c), 32'(commit_valid), 32'd0);
        end
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checkOutput($sformatf("rst.after%0d.flush", c), 32'(flush), 32'd0);
            checkOutput($sformatf("rst.after%0d.valid", c), 32'(commit_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_pipe_tracker.md
EXC_PIPE_TRACKER -- requirements
Module: exc_pipe_tracker

Interface
REQ-001 SHALL have parameter NSTAGE, default 4, number of pipeline stages that can raise exceptions (min 2).
REQ-002 SHALL have parameter CODE_W, default 5, exception code width.
REQ-003 SHALL have parameter ADDR_W, default 32, PC/EPC width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port exc_req  input  NSTAGE  per-stage exception raise, bit 0 = fetch.
REQ-007 SHALL have port exc_code  input  NSTAGE*CODE_W  per-stage code, slice i belongs to stage i.
REQ-008 SHALL have port stage_pc  input  NSTAGE*ADDR_W  PC of the instruction currently in stage i.
REQ-009 SHALL have port hold  input  NSTAGE-1  hold[i] freezes inter-stage register i (between stage i and i+1).
REQ-010 SHALL have port int_req  input  1  level-sensitive external interrupt request.
REQ-011 SHALL have port commit_ack  input  1  CP0 accepted the committed exception.
REQ-012 SHALL have port commit_valid  output  1  exception/interrupt pending to CP0.
REQ-013 SHALL have port commit_code  output  CODE_W  committed code (0 = interrupt).
REQ-014 SHALL have port commit_epc  output  ADDR_W  PC of the faulting instruction.
REQ-015 SHALL have port flush  output  1  one-cycle pulse, kill all in-flight instructions.

Function
REQ-016 SHALL keep NSTAGE-1 inter-stage registers, each holding {valid, code, epc}.
REQ-017 SHALL merge at each stage: an incoming valid entry is kept; a new exc_req at that stage is recorded only if the incoming entry is not valid (earliest detection wins).
REQ-018 SHALL, when hold[i]=1, keep register i; if hold[i]=1 and hold[i+1]=0, load register i+1 with an invalid bubble.
REQ-019 SHALL form the final-stage result combinationally from register NSTAGE-2 and exc_req[NSTAGE-1], and register it into commit outputs: final-stage raise at cycle t gives commit_valid at t+1.
REQ-020 SHALL, when final stage has no exception and int_req=1, commit code 0 with epc = stage_pc of final stage.
REQ-021 SHALL hold commit_valid, commit_code, commit_epc stable while commit_valid=1 and commit_ack=0; all inter-stage registers freeze in this state, new exc_req ignored.
REQ-022 SHALL, on commit_valid=1 and commit_ack=1, clear commit_valid next cycle, pulse flush for exactly that cycle, and clear every inter-stage register valid bit.
REQ-023 SHALL treat commit_ack while commit_valid=0 as no-op.
REQ-024 SHALL implement states IDLE (tracking), PEND (commit_valid=1, waiting ack), FLUSH (one cycle, flush=1) then return to IDLE; FLUSH ignores exc_req and int_req.
REQ-025 SHALL prioritise a same-cycle final-stage exception over int_req.

Reset
REQ-026 SHALL on reset=0 asynchronously force state IDLE, all register valids 0, commit_valid 0, commit_code 0, commit_epc 0, flush 0.
REQ-027 SHALL on reset mid-PEND drop the pending commit without flush pulse.

Configuration
REQ-028 SHALL honour macro EXC_TRACKER_EPC_EN: defined, epc fields are tracked per REQ-016..020; undefined, no epc storage is built, stage_pc ignored, commit_epc tied to 0.

Structure
REQ-029 SHALL place state encoding and code constants (INT=0, ADEL=4, ADES=5, RI=10, OV=12) in shared package exc_pkg.
REQ-030 SHALL implement one sub-module exc_stage_reg (one inter-stage register with merge, hold, bubble, clear), instantiated NSTAGE-1 times.

Verification
REQ-031 SHALL test: exc_req[0] code 4 at t0, no holds -> commit_valid=1, code 4 at t0+4; ack -> flush pulse next cycle.
REQ-032 SHALL test: stage0 code 4 then stage1 code 10 same instruction -> commit code 4 (earliest wins).
REQ-033 SHALL test: hold[1]=1 for 3 cycles during stage1 code 10 -> commit delayed 3 cycles, no duplicate commit.
REQ-034 SHALL test: int_req=1 with final-stage code 12 same cycle -> commit code 12; after ack+flush, int_req still 1 -> commit code 0.
REQ-035 SHALL test: commit_ack held 0 for 5 cycles -> outputs stable, new exc_req[2] code 5 not committed.
REQ-036 SHALL test: reset=0 asserted in PEND -> commit_valid 0 immediately, flush never pulses.
